// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, pixel codes and reset threshold for the Sobel edge path
package sobel_pkg;
    localparam int SUM_W = 10;
    localparam int MAG_W = 11;
    localparam logic [15:0] PIX_WHITE = 16'hFFFF;
    localparam logic [15:0] PIX_BLACK = 16'h0000;
    localparam logic [7:0] DEF_THRESH = 8'd80;

    function automatic logic [7:0] sat_mag(input logic [MAG_W-1:0] m);
        return (m > MAG_W'(255)) ? 8'hFF : m[7:0];
    endfunction
endpackage

// File: rtl/sobel_grad_axis.sv
// sobel_grad_axis: two-stage weighted 1-2-1 sums of opposite window edges, then their absolute difference
module sobel_grad_axis
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic [DATA_W-1:0] pos_a,
    input  logic [DATA_W-1:0] pos_b,
    input  logic [DATA_W-1:0] pos_c,
    input  logic [DATA_W-1:0] neg_a,
    input  logic [DATA_W-1:0] neg_b,
    input  logic [DATA_W-1:0] neg_c,
    output logic [SUM_W-1:0]  abs_diff
);
    logic [SUM_W-1:0] pos_sum, neg_sum;
    logic signed [SUM_W:0] diff;

    // one extra bit keeps the difference signed without wrapping
    always_comb diff = $signed({1'b0, pos_sum}) - $signed({1'b0, neg_sum});

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            pos_sum  <= '0;
            neg_sum  <= '0;
            abs_diff <= '0;
        end else begin
            pos_sum  <= SUM_W'(pos_a) + SUM_W'({pos_b, 1'b0}) + SUM_W'(pos_c);
            neg_sum  <= SUM_W'(neg_a) + SUM_W'({neg_b, 1'b0}) + SUM_W'(neg_c);
            abs_diff <= diff[SUM_W] ? SUM_W'(-diff) : SUM_W'(diff);
        end
    end
endmodule

// File: rtl/sobel_edge_detect.sv
// sobel_edge_detect: Sobel magnitude, per-line threshold, RGB565 black/white output and per-line edge count
module sobel_edge_detect
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W = 11,
    parameter logic [7:0] DEF_THRESH = sobel_pkg::DEF_THRESH
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic [DATA_W-1:0] matrix_p11,
    input  logic [DATA_W-1:0] matrix_p12,
    input  logic [DATA_W-1:0] matrix_p13,
    input  logic [DATA_W-1:0] matrix_p21,
    input  logic [DATA_W-1:0] matrix_p22,
    input  logic [DATA_W-1:0] matrix_p23,
    input  logic [DATA_W-1:0] matrix_p31,
    input  logic [DATA_W-1:0] matrix_p32,
    input  logic [DATA_W-1:0] matrix_p33,
    input  logic              process_href,
    input  logic              process_wrreq,
    input  logic [7:0]        threshold,
    output logic              edge_href,
    output logic              edge_wrreq,
    output logic [15:0]       edge_wrdata,
    output logic [7:0]        edge_mag,
    output logic [CNT_W-1:0]  line_edge_cnt,
    output logic              line_done
);
    logic href_d1, href_d2, wrreq_d1, wrreq_d2, href_prev, edge_href_prev;
    logic [7:0] thresh_lat;
    logic [SUM_W-1:0] gx_abs, gy_abs;
    logic [MAG_W-1:0] mag;
    logic is_edge, pix_edge;
    logic [CNT_W-1:0] cnt;

    sobel_grad_axis #(.DATA_W(DATA_W)) u_gx (
        .sclk(sclk), .s_rst(s_rst),
        .pos_a(matrix_p13), .pos_b(matrix_p23), .pos_c(matrix_p33),
        .neg_a(matrix_p11), .neg_b(matrix_p21), .neg_c(matrix_p31),
        .abs_diff(gx_abs)
    );

    sobel_grad_axis #(.DATA_W(DATA_W)) u_gy (
        .sclk(sclk), .s_rst(s_rst),
        .pos_a(matrix_p31), .pos_b(matrix_p32), .pos_c(matrix_p33),
        .neg_a(matrix_p11), .neg_b(matrix_p12), .neg_c(matrix_p13),
        .abs_diff(gy_abs)
    );

    always_comb begin
        mag      = MAG_W'(gx_abs) + MAG_W'(gy_abs);
        is_edge  = mag >= {3'b0, thresh_lat};
        pix_edge = edge_wrreq & edge_wrdata[0];
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            href_d1     <= 1'b0;
            href_d2     <= 1'b0;
            wrreq_d1    <= 1'b0;
            wrreq_d2    <= 1'b0;
            href_prev   <= 1'b0;
            thresh_lat  <= DEF_THRESH;
            edge_href   <= 1'b0;
            edge_wrreq  <= 1'b0;
            edge_wrdata <= PIX_BLACK;
            edge_mag    <= '0;
        end else begin
            href_d1     <= process_href;
            href_d2     <= href_d1;
            wrreq_d1    <= process_wrreq;
            wrreq_d2    <= wrreq_d1;
            href_prev   <= process_href;
            thresh_lat  <= (process_href & ~href_prev) ? threshold : thresh_lat;
            edge_href   <= href_d2;
            edge_wrreq  <= wrreq_d2;
            edge_wrdata <= (href_d2 & is_edge) ? PIX_WHITE : PIX_BLACK;
            edge_mag    <= href_d2 ? sat_mag(mag) : 8'h00;
        end
    end

    // line statistics are taken on the output side so they line up with what the writer sees
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            edge_href_prev <= 1'b0;
            cnt            <= '0;
            line_edge_cnt  <= '0;
            line_done      <= 1'b0;
        end else begin
            edge_href_prev <= edge_href;
            line_done      <= ~edge_href & edge_href_prev;
            if (edge_href & ~edge_href_prev)
                cnt <= CNT_W'(pix_edge);
            else if (edge_href & pix_edge & ~&cnt)
                cnt <= cnt + CNT_W'(1);
            if (~edge_href & edge_href_prev)
                line_edge_cnt <= cnt;
        end
    end
endmodule

// File: tb/tb_sobel_edge_detect.sv
// tb_sobel_edge_detect: directed and random windows against an integer Sobel model, scoreboard-checked
module tb_sobel_edge_detect;
    typedef int win_t[9];
    typedef struct {
        int          cyc;
        logic        href;
        logic [15:0] data;
        logic [7:0]  mag;
    } pix_t;

    logic        sclk = 1'b0;
    logic        s_rst;
    logic        process_href, process_wrreq;
    logic [7:0]  threshold;
    logic        edge_href, edge_wrreq, line_done;
    logic [15:0] edge_wrdata;
    logic [7:0]  edge_mag;
    logic [10:0] line_edge_cnt;
    win_t        w = '{default: 0};

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    pix_t pix_q[$];
    int   line_q[$];
    logic m_prev = 1'b0;
    int   m_thr = 80;
    int   m_cnt = 0;
    logic ld_prev = 1'b0;

    sobel_edge_detect dut (
        .sclk(sclk), .s_rst(s_rst),
        .matrix_p11(8'(w[0])), .matrix_p12(8'(w[1])), .matrix_p13(8'(w[2])),
        .matrix_p21(8'(w[3])), .matrix_p22(8'(w[4])), .matrix_p23(8'(w[5])),
        .matrix_p31(8'(w[6])), .matrix_p32(8'(w[7])), .matrix_p33(8'(w[8])),
        .process_href(process_href), .process_wrreq(process_wrreq), .threshold(threshold),
        .edge_href(edge_href), .edge_wrreq(edge_wrreq), .edge_wrdata(edge_wrdata),
        .edge_mag(edge_mag), .line_edge_cnt(line_edge_cnt), .line_done(line_done)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int sobel_mag(input win_t p);
        int gx, gy;
        gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
        gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    function automatic win_t flat(input int v);
        win_t r = '{default: v};
        return r;
    endfunction

    function automatic win_t only23(input int v);
        win_t r = '{default: 0};
        r[5] = v;
        return r;
    endfunction

    function automatic win_t vert();
        win_t r = '{default: 0};
        r[2] = 255; r[5] = 255; r[8] = 255;
        return r;
    endfunction

    function automatic win_t rnd_win();
        win_t r;
        for (int i = 0; i < 9; i++) r[i] = int'($urandom_range(0, 255));
        return r;
    endfunction

    // one input cycle; the model works per line: threshold taken at line start, edges counted per line
    task automatic drive(input win_t win, input logic h, input logic r, input int thr);
        int   m;
        logic e;
        @(posedge sclk);
        #1;
        w = win;
        process_href = h;
        process_wrreq = r;
        threshold = 8'(thr);
        m = sobel_mag(win);
        if (h && !m_prev) begin
            m_thr = thr;
            m_cnt = 0;
        end
        if (!h && m_prev) line_q.push_back(m_cnt);
        m_prev = h;
        e = h && (m >= m_thr);
        if (r) pix_q.push_back('{cyc, h, e ? 16'hFFFF : 16'h0000, h ? 8'(m > 255 ? 255 : m) : 8'h00});
        if (e && r && m_cnt < 2047) m_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(flat(0), 1'b0, 1'b0, 80);
    endtask

    task automatic line(input win_t win, input int n, input int thr);
        for (int i = 0; i < n; i++) drive(win, 1'b1, 1'b1, thr);
        idle(5);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_edge_href"}, edge_href, 0);
        check({tag, "_edge_wrreq"}, edge_wrreq, 0);
        check({tag, "_edge_wrdata"}, edge_wrdata, 0);
        check({tag, "_edge_mag"}, edge_mag, 0);
        check({tag, "_line_edge_cnt"}, line_edge_cnt, 0);
        check({tag, "_line_done"}, line_done, 0);
    endtask

    always @(negedge sclk) begin
        if (!s_rst) begin
            if (edge_wrreq) begin
                if (pix_q.size() == 0) check("spurious_pixel", 1, 0);
                else begin
                    pix_t e;
                    e = pix_q.pop_front();
                    check("latency", cyc, e.cyc + 3);
                    check("edge_href", edge_href, e.href);
                    check("edge_wrdata", edge_wrdata, e.data);
                    check("edge_mag", edge_mag, e.mag);
                end
            end
            if (line_done) begin
                check("line_done_width", ld_prev, 0);
                if (line_q.size() == 0) check("spurious_line_done", 1, 0);
                else check("line_edge_cnt", line_edge_cnt, line_q.pop_front());
            end
            ld_prev <= line_done;
        end else ld_prev <= 1'b0;
    end

    initial begin
        s_rst = 1'b1;
        process_href = 1'b0;
        process_wrreq = 1'b0;
        threshold = 8'd80;
        @(posedge sclk);
        #1;
        check_reset_outputs("rst");
        @(posedge sclk);
        #1 s_rst = 1'b0;

        line(flat(100), 8, 80);
        line(vert(), 4, 80);
        drive(only23(40), 1'b1, 1'b1, 80);
        drive(only23(39), 1'b1, 1'b1, 80);
        idle(5);
        for (int i = 0; i < 5; i++) drive(vert(), 1'b1, (i % 2) == 0, 80);
        idle(5);
        for (int i = 0; i < 6; i++) drive(only23(80), 1'b1, 1'b1, i < 3 ? 80 : 200);
        idle(2);
        line(only23(80), 4, 200);
        for (int i = 0; i < 10; i++) drive((i % 3) == 0 ? vert() : flat(30), 1'b1, 1'b1, 80);
        idle(5);
        for (int i = 0; i < 5; i++) drive(vert(), 1'b1, 1'b1, 50);
        @(posedge sclk);
        #1;
        s_rst = 1'b1;
        process_href = 1'b0;
        process_wrreq = 1'b0;
        #1;
        check_reset_outputs("midline_rst");
        pix_q.delete();
        line_q.delete();
        m_prev = 1'b0;
        repeat (2) @(posedge sclk);
        #1 s_rst = 1'b0;
        line(only23(40), 3, 80);
        drive(flat(0), 1'b0, 1'b1, 0);
        drive(vert(), 1'b0, 1'b1, 0);
        idle(4);
        line(vert(), 2100, 0);

        for (int l = 0; l < 20; l++) begin
            int len = int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++)
                drive(rnd_win(), 1'b1, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
            for (int i = 0; i < int'($urandom_range(1, 4)); i++)
                drive(rnd_win(), 1'b0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
        end
        idle(8);
        check("pix_q_drained", pix_q.size(), 0);
        check("line_q_drained", line_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
